// File: rtl/comp_seq.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the MSB end,
// optionally stopping at the first differing slice; signed mode via MSB flip.
module comp_seq #(
   parameter int WIDTH      = 32,
   parameter int CHUNK      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              gti_q, gti_d;
   logic              lti_q, lti_d;
   logic              gt_q, gt_d;
   logic              lt_q, lt_d;
   logic              eq_q, eq_d;

   logic [CHUNK-1:0]  chunk_a [NCHUNK];
   logic [CHUNK-1:0]  chunk_b [NCHUNK];
   logic [CHUNK-1:0]  cur_a, cur_b;
   logic [WIDTH-1:0]  sign_mask;
   logic              accept;
   logic              first_diff;
   logic              gti_run, lti_run;
   logic              last;

   genvar gi;
   generate
      for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign chunk_a[gi] = a_q[gi*CHUNK +: CHUNK];
         assign chunk_b[gi] = b_q[gi*CHUNK +: CHUNK];
      end
   endgenerate

   assign cur_a = chunk_a[idx_q];
   assign cur_b = chunk_b[idx_q];

   // Flipping the sign bit maps two's complement onto offset binary, so the
   // unsigned slice compare yields the signed ordering.
   assign sign_mask  = {sgn, {(WIDTH-1){1'b0}}};
   assign accept     = (state_q != RUN) && start;
   assign first_diff = (cur_a != cur_b) && !(gti_q || lti_q);
   assign gti_run    = gti_q || (first_diff && (cur_a > cur_b));
   assign lti_run    = lti_q || (first_diff && (cur_a < cur_b));
   assign last       = (idx_q == '0) || ((EARLY_EXIT != 0) && first_diff);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = start ? RUN : IDLE;
         RUN:        state_d = last ? DONE : RUN;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath next-state
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      idx_d = idx_q;
      gti_d = gti_q;
      lti_d = lti_q;
      gt_d  = gt_q;
      lt_d  = lt_q;
      eq_d  = eq_q;
      if (accept) begin
         a_d   = a ^ sign_mask;
         b_d   = b ^ sign_mask;
         idx_d = IDXW'(NCHUNK - 1);
         gti_d = 1'b0;
         lti_d = 1'b0;
      end else if (state_q == RUN) begin
         gti_d = gti_run;
         lti_d = lti_run;
         if (last) begin
            gt_d = gti_run;
            lt_d = lti_run;
            eq_d = !(gti_run || lti_run);
         end else begin
            idx_d = idx_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         idx_q <= '0;
         gti_q <= 1'b0;
         lti_q <= 1'b0;
         gt_q  <= 1'b0;
         lt_q  <= 1'b0;
         eq_q  <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         idx_q <= idx_d;
         gti_q <= gti_d;
         lti_q <= lti_d;
         gt_q  <= gt_d;
         lt_q  <= lt_d;
         eq_q  <= eq_d;
      end
   end

   // Output logic
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      gt   = gt_q;
      lt   = lt_q;
      eq   = eq_q;
   end

endmodule
